ring_chaser_checker: RTL



---
 rtl/ring_chaser_checker_pkg.sv | 37 +++
 rtl/ring_chaser_checker_if.sv | 31 +++
 rtl/ring_chaser_checker_sync_stable_filter.sv | 66 ++++++
 rtl/ring_chaser_checker.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ring_chaser_checker_pkg.sv
// Shared types and helpers for the ring chaser checker.
// Contents: FSM state enum, default ring width, and one-hot helper
// functions that work on a MAX_W-bit vector. Callers zero-extend their
// patterns into that vector.
package ring_chk_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int MAX_W         = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  function automatic logic is_onehot(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
  endfunction

  // Returns the index of the highest set bit. This is only meaningful
  // when v is one-hot.
  function automatic int onehot_to_idx(input logic [MAX_W-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Rotates v left by one position within the low 'width' bits.
  function automatic logic [MAX_W-1:0] next_onehot(input logic [MAX_W-1:0] v,
                                                    input int width);
    if (v[width-1]) return MAX_W'(1);
    return v << 1;
  endfunction

endpackage

// File: rtl/ring_chaser_checker_if.sv
// Status and control bundle of the ring chaser checker.
// Signal directions by modport:
//   master (driver/observer side):
//     drives pat_in and clr_err;
//     reads pos_idx, pos_valid, locked, step_pulse, lap_cnt and err_sticky.
//   slave (checker side): the mirror of master.
interface ring_chk_if #(
  parameter int WIDTH = 6,
  parameter int LAP_W = 4
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] pat_in;
  logic             clr_err;
  logic [IDX_W-1:0] pos_idx;
  logic             pos_valid;
  logic             locked;
  logic             step_pulse;
  logic [LAP_W-1:0] lap_cnt;
  logic             err_sticky;

  modport master (
    output pat_in, clr_err,
    input  pos_idx, pos_valid, locked, step_pulse, lap_cnt, err_sticky
  );

  modport slave (
    input  pat_in, clr_err,
    output pos_idx, pos_valid, locked, step_pulse, lap_cnt, err_sticky
  );
endinterface

// File: rtl/ring_chaser_checker_sync_stable_filter.sv
// Synchroniser and stability filter for the asynchronous chaser pattern.
// Ports:
//   clk, reset  system clock and async active-high reset
//   pat_in      raw pattern (asynchronous to clk)
//   acc         accepted pattern; while accept is high it carries the value
//               being accepted on this edge
//   accept      one-cycle strobe, asserted on the edge where a new stable
//               value is taken
module sync_stable_filter #(
  parameter int WIDTH         = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_in,
  output logic [WIDTH-1:0] acc,
  output logic             accept
);
  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] syn;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    sync_d[0] = pat_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    syn = sync_q[SYNC_STAGES-1];

    if (syn != cand_q) begin
      cand_d = syn;
      cnt_d  = CNT_W'(1);
    end else begin
      cand_d = cand_q;
      cnt_d  = (cnt_q == STABLE_V) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Acceptance is decided from the next-state values so that the top level
    // can register its outputs on the same edge. With STABLE_CYCLES=1 this
    // also covers acceptance on the very edge where the candidate changes.
    accept = (cnt_d == STABLE_V) && (cand_d != acc_q);
    acc_d  = accept ? cand_d : acc_q;
  end

  assign acc = acc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/ring_chaser_checker.sv
// Receive-side checker for the ring chaser.
// Filters the asynchronous pattern, decodes the one-hot position, tracks the
// legal rotation sequence, counts laps and latches protocol errors.
// Ports:
//   clk, reset  system clock and async active-high reset
//   bus         ring_chk_if.slave
//               inputs:  pat_in, clr_err
//               outputs: pos_idx, pos_valid, locked, step_pulse, lap_cnt,
//                        err_sticky (all registered)
module ring_chaser_checker
  import ring_chk_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int LAP_W         = 4
) (
  input  logic      clk,
  input  logic      reset,
  ring_chk_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc;
  logic             accept;

  sync_stable_filter #(
    .WIDTH         (WIDTH),
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .pat_in (bus.pat_in),
    .acc    (acc),
    .accept (accept)
  );

  chk_state_e       state_q, state_d;
  logic [IDX_W-1:0] pos_idx_q, pos_idx_d;
  logic             pos_valid_q, pos_valid_d;
  logic             step_q, step_d;
  logic [LAP_W-1:0] lap_q, lap_d;
  logic             err_q, err_d;

  logic             acc_oh;
  logic [IDX_W-1:0] acc_idx;
  logic [WIDTH-1:0] prev_pat;
  logic             succ;
  logic             err_evt;

  always_comb begin
    acc_oh   = is_onehot(MAX_W'(acc));
    acc_idx  = IDX_W'(onehot_to_idx(MAX_W'(acc)));
    // While LOCKED the previously accepted value is one-hot, so it can be
    // rebuilt from pos_idx without keeping a separate copy.
    prev_pat = WIDTH'(1) << pos_idx_q;
    succ     = (acc == WIDTH'(next_onehot(MAX_W'(prev_pat), WIDTH)));

    state_d     = state_q;
    pos_idx_d   = pos_idx_q;
    pos_valid_d = pos_valid_q;
    step_d      = 1'b0;
    lap_d       = lap_q;
    err_evt     = 1'b0;

    if (accept) begin
      pos_valid_d = acc_oh;
      if (acc_oh) pos_idx_d = acc_idx;
      case (state_q)
        SEARCH: begin
          if (acc_oh) state_d = LOCKED;
          else if (acc != '0) err_evt = 1'b1;
        end
        LOCKED: begin
          if (succ) begin
            step_d = 1'b1;
            // The successor is bit 0 only when wrapping from bit WIDTH-1.
            if (acc_idx == '0) lap_d = lap_q + LAP_W'(1);
          end else begin
            err_evt = 1'b1;
            state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // A new error takes priority over a clear arriving in the same cycle.
    if (err_evt) err_d = 1'b1;
    else if (bus.clr_err) err_d = 1'b0;
    else err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      pos_idx_q   <= '0;
      pos_valid_q <= 1'b0;
      step_q      <= 1'b0;
      lap_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_idx_q   <= pos_idx_d;
      pos_valid_q <= pos_valid_d;
      step_q      <= step_d;
      lap_q       <= lap_d;
      err_q       <= err_d;
    end
  end

  assign bus.pos_idx    = pos_idx_q;
  assign bus.pos_valid  = pos_valid_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.step_pulse = step_q;
  assign bus.lap_cnt    = lap_q;
  assign bus.err_sticky = err_q;

endmodule
